simple_c_monitor: RTL and testbench
===================================

// Module: simple_c_monitor
// PURPOSE
// Downstream consumer of the gate-level D/E combinational outputs. Those outputs are asynchronous and glitch
// during gate settling. Synchronizes and deglitches both lines, detects level changes, counts rising edges,
// and queues timestamped change events through a valid/ready interface for a logger or checker.
// PARAMETERS
// SYNC_STAGES    2  flops per input synchronizer (>=2)
// STABLE_CYCLES  4  consecutive sampled cycles a new level must hold before acceptance (>=1)
// CNT_W          8  rising-edge counter width
// TS_W           8  free-running timestamp width
// FIFO_DEPTH     4  event queue entries (>=2)
// PORTS
// clk          in   1        sole clock, rising edge
// rst_n        in   1        asynchronous, active-low reset
// d_in         in   1        raw D line (asynchronous)
// e_in         in   1        raw E line (asynchronous)
// clear        in   1        sync clear: counters, overflow, FIFO
// d_level      out  1        filtered D
// e_level      out  1        filtered E
// d_rise_cnt   out  CNT_W    filtered D 0->1 count, saturating
// e_rise_cnt   out  CNT_W    filtered E 0->1 count, saturating
// overflow     out  1        sticky: an event was dropped
// evt_valid    out  1        FIFO non-empty
// evt_ready    in   1        consumer accepts head entry
// evt_data     out  TS_W+2   [TS_W+1]=sig_id (0=D,1=E), [TS_W]=new level, [TS_W-1:0]=timestamp
// BEHAVIOUR
// - Reset value of every flop and output is 0, including levels, counters, ts, FIFO pointers, overflow and evt_valid.
//   Assertion is immediate and asynchronous; a mid-transfer reset drops evt_valid at once and loses queued events.
// - Sync: each input passes through SYNC_STAGES flops. An input changing before edge 1 appears at sync output after edge SYNC_STAGES.
// - Filter (per line, counter stab): if sync!=level then: if stab==STABLE_CYCLES-1 then level<=sync and stab<=0,
//   else stab++. If sync==level, stab<=0. Total latency from input change to level change is SYNC_STAGES+STABLE_CYCLES edges.
//   Any excursion shorter than STABLE_CYCLES sampled cycles produces no level change, no event and no count.
// - ts: increments every edge and wraps 2^TS_W-1 -> 0. An event records ts as registered before that edge's increment.
// - A level change at an edge creates one event. A 0->1 change also increments the rise counter, which holds at 2^CNT_W-1.
// - FIFO: show-ahead. evt_data is the head entry whenever evt_valid=1. A pop occurs on evt_valid&&evt_ready.
//   evt_ready while empty has no effect. evt_data is don't-care when evt_valid=0.
// - Up to 2 pushes per cycle. When D and E change on the same edge, the D entry is written ahead of the E entry.
// - Free space is FIFO_DEPTH-count+pop, so a same-cycle pop frees a slot for that cycle's push.
// - Events beyond free space are dropped, E first, and overflow<=1. Counters still update for dropped events.
// - clear (synchronous): rise counters<=0, overflow<=0, FIFO flushed (evt_valid=0 next cycle). Sync, filter, levels and ts
//   are unaffected. clear wins over same-edge events: the event is not queued, the counter reads 0 and overflow stays 0.
// - Idle gate outputs are D=1, E=1 (all gate inputs 0). After reset both levels rise at edge 6 and queue D then E.
// TESTING (defaults)
// 1 rst_n released with d_in=e_in=1, evt_ready=0 -> at edge 6 levels=1, counts=1/1;
//   FIFO holds {0,1,ts=5} then {1,1,ts=5}. Then ready=1 -> D entry, then E entry pop on consecutive cycles.
// 2 e_in low for 3 cycles then back high -> no event, e_level stays 1. A 4-cycle low pulse -> fall event, then rise event, e_rise_cnt=2.
// 3 evt_ready=0, toggle d_in 5 times, each hold 8 cycles -> 4 entries queued, overflow=1, 5th dropped, d_rise_cnt correct.
// 4 FIFO full with evt_ready=1 on the same edge as a new event -> pop and push both occur, count stays 4, overflow stays 0.
// 5 300 filtered D rises -> d_rise_cnt=255, then clear -> counters 0, evt_valid 0.
//   clear coincident with an E rise -> no entry queued, e_rise_cnt=0.
// 6 rst_n low mid-stream with 3 entries queued -> evt_valid, levels, counts, ts all 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/simple_c_monitor.sv
// Synchronizes and deglitches the asynchronous D/E gate outputs, counts filtered rising edges
// and queues timestamped level-change events for a downstream consumer over valid/ready.
module simple_c_monitor #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8,
   parameter int unsigned TS_W          = 8,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             d_in,
   input  logic             e_in,
   input  logic             clear,
   output logic             d_level,
   output logic             e_level,
   output logic [CNT_W-1:0] d_rise_cnt,
   output logic [CNT_W-1:0] e_rise_cnt,
   output logic             overflow,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [TS_W+1:0]  evt_data
);
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_FW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int unsigned EW     = TS_W + 2;
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   // Index 0 is the D line, index 1 the E line throughout.
   logic [SYNC_STAGES-1:0] sync_q [2];
   logic [STAB_W-1:0]      stab_q [2];
   logic [CNT_W-1:0]       rise_cnt_q [2];
   logic [1:0]             level_q;
   logic [1:0]             samp;
   logic [1:0]             chg;
   logic [1:0]             rise;
   logic [TS_W-1:0]        ts_q;
   logic                   overflow_q;
   logic [EW-1:0]          mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [CNT_FW-1:0]      count_q;

   logic                   pop;
   logic                   push_d;
   logic                   push_e;
   logic                   drop;
   logic [CNT_FW-1:0]      free;
   logic [CNT_FW-1:0]      n_push;
   logic [EW-1:0]          entry0;
   logic [EW-1:0]          entry1;

   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input int unsigned n);
      int unsigned s;
      s = 32'(p) + n;
      if (s >= FIFO_DEPTH) s = s - FIFO_DEPTH;
      return PTR_W'(s);
   endfunction

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         samp[i] = sync_q[i][SYNC_STAGES-1];
         chg[i]  = (samp[i] != level_q[i]) && (stab_q[i] == STAB_LAST);
         rise[i] = chg[i] && samp[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            sync_q[i] <= '0;
            stab_q[i] <= '0;
         end
         level_q <= '0;
         ts_q    <= '0;
      end else begin
         sync_q[0] <= {sync_q[0][SYNC_STAGES-2:0], d_in};
         sync_q[1] <= {sync_q[1][SYNC_STAGES-2:0], e_in};
         ts_q      <= ts_q + TS_W'(1);
         for (int i = 0; i < 2; i++) begin
            if (samp[i] == level_q[i]) begin
               stab_q[i] <= '0;
            end else if (chg[i]) begin
               level_q[i] <= samp[i];
               stab_q[i]  <= '0;
            end else begin
               stab_q[i] <= stab_q[i] + STAB_W'(1);
            end
         end
      end
   end

   // A same-cycle pop frees a slot; when short of space D is kept and E dropped.
   always_comb begin
      pop    = evt_valid && evt_ready;
      free   = CNT_FW'(FIFO_DEPTH) - count_q + CNT_FW'(pop);
      push_d = chg[0] && (free != '0);
      push_e = chg[1] && (free > (chg[0] ? CNT_FW'(1) : CNT_FW'(0)));
      drop   = (chg[0] && !push_d) || (chg[1] && !push_e);
      n_push = CNT_FW'(push_d) + CNT_FW'(push_e);
      entry0 = chg[0] ? {1'b0, samp[0], ts_q} : {1'b1, samp[1], ts_q};
      entry1 = {1'b1, samp[1], ts_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         rise_cnt_q[0] <= '0;
         rise_cnt_q[1] <= '0;
      end else if (clear) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         rise_cnt_q[0] <= '0;
         rise_cnt_q[1] <= '0;
      end else begin
         if (push_d || push_e) mem_q[wr_ptr_q] <= entry0;
         if (push_d && push_e) mem_q[ptr_add(wr_ptr_q, 1)] <= entry1;
         wr_ptr_q <= ptr_add(wr_ptr_q, 32'(n_push));
         if (pop) rd_ptr_q <= ptr_add(rd_ptr_q, 1);
         count_q <= count_q + n_push - CNT_FW'(pop);
         if (drop) overflow_q <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            if (rise[i] && (rise_cnt_q[i] != CNT_MAX)) begin
               rise_cnt_q[i] <= rise_cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign d_level    = level_q[0];
   assign e_level    = level_q[1];
   assign d_rise_cnt = rise_cnt_q[0];
   assign e_rise_cnt = rise_cnt_q[1];
   assign overflow   = overflow_q;
   assign evt_valid  = (count_q != '0);
   assign evt_data   = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_simple_c_monitor.sv
// Bench for simple_c_monitor: expected events are queued as stimulus is driven, using the
// input-to-level latency of SYNC_STAGES+STABLE_CYCLES edges, and compared as the FIFO drains.
module tb_simple_c_monitor;
   localparam int unsigned TS_W  = 8;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             d_in;
   logic             e_in;
   logic             clear;
   logic             d_level;
   logic             e_level;
   logic [CNT_W-1:0] d_rise_cnt;
   logic [CNT_W-1:0] e_rise_cnt;
   logic             overflow;
   logic             evt_valid;
   logic             evt_ready;
   logic [TS_W+1:0]  evt_data;

   int               vectors = 0;
   int               miscompares = 0;
   int unsigned      cyc;
   logic [TS_W+1:0]  exp_q [$];

   simple_c_monitor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .d_in       (d_in),
      .e_in       (e_in),
      .clear      (clear),
      .d_level    (d_level),
      .e_level    (e_level),
      .d_rise_cnt (d_rise_cnt),
      .e_rise_cnt (e_rise_cnt),
      .overflow   (overflow),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_data   (evt_data)
   );

   always #5 clk = ~clk;

   // Edges since reset release; the timestamp register should track this value.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Change takes effect 6 edges later and records the timestamp of the edge before.
   task automatic drive(input bit sel_e, input logic v, input bit queued);
      if (sel_e) e_in = v;
      else       d_in = v;
      if (queued) exp_q.push_back({sel_e, v, TS_W'(cyc + 5)});
   endtask

   task automatic test_reset();
      rst_n = 1'b0; d_in = 1'b1; e_in = 1'b1; clear = 1'b0; evt_ready = 1'b0;
      tick(3);
      vectors++;
      if ({d_level, e_level, overflow, evt_valid} !== 4'b0 || d_rise_cnt !== 0 ||
          e_rise_cnt !== 0) begin
         miscompares++;
         $display("FAIL reset_state: got lvl=%b%b ovf=%b vld=%b cnt=%0d/%0d, want all 0",
                  d_level, e_level, overflow, evt_valid, d_rise_cnt, e_rise_cnt);
      end
      #2 rst_n = 1'b1;
      drive(0, 1'b1, 1'b1);
      drive(1, 1'b1, 1'b1);
      tick(5);
      vectors++;
      if ({d_level, e_level} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_edge5: got levels=%b%b, want 00", d_level, e_level);
      end
      tick(1);
      vectors++;
      if ({d_level, e_level, evt_valid} !== 3'b111 || d_rise_cnt !== 1 || e_rise_cnt !== 1) begin
         miscompares++;
         $display("FAIL reset_edge6: got lvl=%b%b vld=%b cnt=%0d/%0d, want 111 1/1",
                  d_level, e_level, evt_valid, d_rise_cnt, e_rise_cnt);
      end
      evt_ready = 1'b1;
      while (exp_q.size() > 0) begin
         vectors++;
         if (evt_valid !== 1'b1 || evt_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL reset_pop: got vld=%b data=%h, want vld=1 data=%h",
                     evt_valid, evt_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick(1);
      end
      evt_ready = 1'b0;
      vectors++;
      if (evt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_empty: got vld=%b, want 0", evt_valid);
      end
   endtask

   task automatic test_glitch();
      drive(1, 1'b0, 1'b0);
      tick(3);
      drive(1, 1'b1, 1'b0);
      tick(12);
      vectors++;
      if (e_level !== 1'b1 || evt_valid !== 1'b0 || e_rise_cnt !== 1) begin
         miscompares++;
         $display("FAIL glitch_3cyc: got e_lvl=%b vld=%b e_cnt=%0d, want 1 0 1",
                  e_level, evt_valid, e_rise_cnt);
      end
      drive(1, 1'b0, 1'b1);
      tick(4);
      drive(1, 1'b1, 1'b1);
      tick(12);
      vectors++;
      if (e_level !== 1'b1 || e_rise_cnt !== 2) begin
         miscompares++;
         $display("FAIL glitch_4cyc: got e_lvl=%b e_cnt=%0d, want 1 2", e_level, e_rise_cnt);
      end
      evt_ready = 1'b1;
      while (exp_q.size() > 0) begin
         vectors++;
         if (evt_valid !== 1'b1 || evt_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL glitch_pop: got vld=%b data=%h, want vld=1 data=%h",
                     evt_valid, evt_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick(1);
      end
      evt_ready = 1'b0;
   endtask

   task automatic test_overflow();
      evt_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(0, (i % 2) == 1, i < 4);
         tick(8);
      end
      vectors++;
      if (overflow !== 1'b1 || d_rise_cnt !== 3 || d_level !== 1'b0 || evt_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_state: got ovf=%b d_cnt=%0d d_lvl=%b vld=%b, want 1 3 0 1",
                  overflow, d_rise_cnt, d_level, evt_valid);
      end
      evt_ready = 1'b1;
      while (exp_q.size() > 0) begin
         vectors++;
         if (evt_valid !== 1'b1 || evt_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL ovf_pop: got vld=%b data=%h, want vld=1 data=%h",
                     evt_valid, evt_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick(1);
      end
      evt_ready = 1'b0;
      vectors++;
      if (evt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_fifth_dropped: got vld=%b, want 0", evt_valid);
      end
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      vectors++;
      if (overflow !== 1'b0 || d_rise_cnt !== 0 || e_rise_cnt !== 0) begin
         miscompares++;
         $display("FAIL ovf_clear: got ovf=%b cnt=%0d/%0d, want 0 0/0",
                  overflow, d_rise_cnt, e_rise_cnt);
      end
   endtask

   task automatic test_full_pop_push();
      evt_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(0, (i % 2) == 0, 1'b1);
         tick(8);
      end
      drive(0, 1'b1, 1'b1);
      tick(5);
      vectors++;
      if (evt_valid !== 1'b1 || evt_data !== exp_q[0]) begin
         miscompares++;
         $display("FAIL full_head: got vld=%b data=%h, want vld=1 data=%h",
                  evt_valid, evt_data, exp_q[0]);
      end
      void'(exp_q.pop_front());
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      vectors++;
      if (overflow !== 1'b0 || d_rise_cnt !== 3) begin
         miscompares++;
         $display("FAIL full_pop_push: got ovf=%b d_cnt=%0d, want 0 3", overflow, d_rise_cnt);
      end
      evt_ready = 1'b1;
      while (exp_q.size() > 0) begin
         vectors++;
         if (evt_valid !== 1'b1 || evt_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL full_pop: got vld=%b data=%h, want vld=1 data=%h",
                     evt_valid, evt_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick(1);
      end
      evt_ready = 1'b0;
      vectors++;
      if (evt_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL full_count: got vld=%b after 4 pops, want 0", evt_valid);
      end
   endtask

   task automatic test_saturate_clear();
      evt_ready = 1'b0;
      for (int i = 0; i < 300; i++) begin
         drive(0, 1'b0, 1'b0);
         tick(5);
         drive(0, 1'b1, 1'b0);
         tick(5);
      end
      tick(3);
      vectors++;
      if (d_rise_cnt !== 8'd255 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_count: got d_cnt=%0d ovf=%b, want 255 1", d_rise_cnt, overflow);
      end
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      vectors++;
      if (d_rise_cnt !== 0 || e_rise_cnt !== 0 || evt_valid !== 1'b0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL sat_clear: got cnt=%0d/%0d vld=%b ovf=%b, want 0/0 0 0",
                  d_rise_cnt, e_rise_cnt, evt_valid, overflow);
      end
      drive(1, 1'b0, 1'b1);
      tick(8);
      evt_ready = 1'b1;
      while (exp_q.size() > 0) begin
         vectors++;
         if (evt_valid !== 1'b1 || evt_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL sat_fall_pop: got vld=%b data=%h, want vld=1 data=%h",
                     evt_valid, evt_data, exp_q[0]);
         end
         void'(exp_q.pop_front());
         tick(1);
      end
      evt_ready = 1'b0;
      drive(1, 1'b1, 1'b0);
      tick(5);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      vectors++;
      if (e_level !== 1'b1 || e_rise_cnt !== 0 || evt_valid !== 1'b0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_vs_rise: got e_lvl=%b e_cnt=%0d vld=%b ovf=%b, want 1 0 0 0",
                  e_level, e_rise_cnt, evt_valid, overflow);
      end
   endtask

   task automatic test_async_reset();
      evt_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(0, (i % 2) == 1, 1'b1);
         tick(8);
      end
      vectors++;
      if (evt_valid !== 1'b1 || e_level !== 1'b1 || d_rise_cnt !== 1) begin
         miscompares++;
         $display("FAIL arst_pre: got vld=%b e_lvl=%b d_cnt=%0d, want 1 1 1",
                  evt_valid, e_level, d_rise_cnt);
      end
      #3 rst_n = 1'b0;
      #1;
      vectors++;
      if ({evt_valid, d_level, e_level, overflow} !== 4'b0 || d_rise_cnt !== 0 ||
          e_rise_cnt !== 0 || dut.ts_q !== 0) begin
         miscompares++;
         $display("FAIL arst_immediate: got vld=%b lvl=%b%b ovf=%b cnt=%0d/%0d ts=%0d, want 0",
                  evt_valid, d_level, e_level, overflow, d_rise_cnt, e_rise_cnt, dut.ts_q);
      end
      exp_q.delete();
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_overflow();
      test_full_pop_push();
      test_saturate_clear();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
